// File: rtl/stream_pkg.sv
// Shared definitions for the stream datapath: default vector geometry,
// the serializer state encoding and the word-index width helper.
package stream_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_CORES  = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Width of a word index for a vector of `cores` words (at least 1 bit).
  function automatic int idx_width(input int cores);
    return (cores > 1) ? $clog2(cores) : 1;
  endfunction

endpackage

// File: rtl/stream_unpacker_if.sv
// Capture/readback bundle of the stream unpacker. The master side is the
// unpacker itself (it sources the output stream); the slave side is the
// surrounding system that supplies vectors and sinks the words.
interface stream_unpacker_if
  import stream_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int CORES  = DEF_CORES
);
  localparam int IWIDTH = idx_width(CORES);

  logic                    LOAD;
  logic [DWIDTH*CORES-1:0] STREAM_I;
  logic                    ABORT;
  logic                    OUT_READY;
  logic                    OUT_VALID;
  logic [DWIDTH-1:0]       OUT_DATA;
  logic [IWIDTH-1:0]       OUT_INDEX;
  logic                    OUT_LAST;
  logic                    BUSY;
  logic                    DONE;
  logic                    OVERRUN;

  modport master (
    input  LOAD, STREAM_I, ABORT, OUT_READY,
    output OUT_VALID, OUT_DATA, OUT_INDEX, OUT_LAST, BUSY, DONE, OVERRUN
  );

  modport slave (
    output LOAD, STREAM_I, ABORT, OUT_READY,
    input  OUT_VALID, OUT_DATA, OUT_INDEX, OUT_LAST, BUSY, DONE, OVERRUN
  );

endinterface

// File: rtl/word_shift_reg.sv
// DWIDTH x CORES shadow register: parallel load of a whole vector, right
// shift by one word with zero fill, word 0 always presented at the output.
module word_shift_reg #(
  parameter int DWIDTH = 32,
  parameter int CORES  = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic                    i_shift,
  input  logic [DWIDTH*CORES-1:0] i_data,
  output logic [DWIDTH-1:0]       o_word
);

  localparam int VWIDTH = DWIDTH * CORES;

  logic [VWIDTH-1:0] r_shadow;

  // Shadow register: load takes priority over shift.
  // NOTE: this wide register is reset on purpose so that no stale frame can
  // ever be observed after reset; use <= so every bit updates from the
  // pre-edge value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
    end else if (i_load) begin
      r_shadow <= i_data;
    end else if (i_shift) begin
      r_shadow <= {{DWIDTH{1'b0}}, r_shadow[VWIDTH-1:DWIDTH]};
    end
  end

  assign o_word = r_shadow[DWIDTH-1:0];

endmodule

// File: rtl/stream_unpacker.sv
// Output-side serializer: captures a CORES-word result vector on LOAD and
// streams it out word 0 first over a valid/ready port, with back-to-back
// frame chaining, abort, and done/overrun status pulses.
module stream_unpacker
  import stream_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int CORES  = DEF_CORES
) (
  input  logic               CLOCK,
  input  logic               NRESET,
  stream_unpacker_if.master  bus
);

  localparam int                IWIDTH   = idx_width(CORES);
  localparam logic [IWIDTH-1:0] LAST_IDX = IWIDTH'(CORES - 1);

  state_t            r_state;
  logic [IWIDTH-1:0] r_index;
  logic              r_done;
  logic              r_overrun;

  state_t            w_state_nxt;
  logic [IWIDTH-1:0] w_index_nxt;
  logic              w_done_nxt;
  logic              w_overrun_nxt;
  logic              w_load;
  logic              w_shift;
  logic              w_valid;
  logic [DWIDTH-1:0] w_word;

  word_shift_reg #(
    .DWIDTH (DWIDTH),
    .CORES  (CORES)
  ) u_shadow (
    .i_clk   (CLOCK),
    .i_rst_n (NRESET),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (bus.STREAM_I),
    .o_word  (w_word)
  );

  // Next-state, capture/shift strobes and status pulses.
  // NOTE: every signal gets its default first so no path leaves one
  // unassigned and a latch is never inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_index_nxt   = r_index;
    w_done_nxt    = 1'b0;
    w_overrun_nxt = 1'b0;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.LOAD && !bus.ABORT) begin
          w_load      = 1'b1;
          w_index_nxt = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (bus.ABORT) begin
          // Remaining words are dropped; the shadow is simply ignored.
          w_state_nxt = IDLE;
          w_index_nxt = '0;
        end else if (bus.OUT_READY) begin
          if (r_index == LAST_IDX) begin
            w_done_nxt  = 1'b1;
            w_index_nxt = '0;
            if (bus.LOAD) begin
              // Chain the next frame with no bubble.
              w_load = 1'b1;
            end else begin
              w_shift     = 1'b1;
              w_state_nxt = IDLE;
            end
          end else begin
            w_shift       = 1'b1;
            w_index_nxt   = r_index + IWIDTH'(1);
            w_overrun_nxt = bus.LOAD;
          end
        end else begin
          w_overrun_nxt = bus.LOAD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, index and one-cycle status flags.
  always_ff @(posedge CLOCK or negedge NRESET) begin
    if (!NRESET) begin
      r_state   <= IDLE;
      r_index   <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_index   <= w_index_nxt;
      r_done    <= w_done_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Outputs decode registers only; data fields are forced to 0 when idle.
  assign w_valid       = (r_state == SEND);
  assign bus.OUT_VALID = w_valid;
  assign bus.OUT_DATA  = w_valid ? w_word : '0;
  assign bus.OUT_INDEX = w_valid ? r_index : '0;
  assign bus.OUT_LAST  = w_valid && (r_index == LAST_IDX);
  assign bus.BUSY      = w_valid;
  assign bus.DONE      = r_done;
  assign bus.OVERRUN   = r_overrun;

endmodule

// File: tb/tb_stream_unpacker.sv
// Directed bench for stream_unpacker with CORES=4, DWIDTH=32.
module tb_stream_unpacker;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam logic [31:0] A_BASE = 32'hA000_0000;
  localparam logic [31:0] B_BASE = 32'hB000_0000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  stream_unpacker_if #(.DWIDTH(DW), .CORES(NC)) bus ();

  stream_unpacker #(.DWIDTH(DW), .CORES(NC)) dut (
    .CLOCK  (clk),
    .NRESET (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  function automatic logic [DW*NC-1:0] vec(input logic [31:0] base);
    logic [DW*NC-1:0] v;
    for (int k = 0; k < NC; k++) v[k*DW +: DW] = base + 32'(k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] base, input int k);
    check({tag, "_valid"}, 32'(bus.OUT_VALID), 32'd1);
    check({tag, "_data"},  bus.OUT_DATA, base + 32'(k));
    check({tag, "_index"}, 32'(bus.OUT_INDEX), 32'(k));
    check({tag, "_last"},  32'(bus.OUT_LAST), (k == NC - 1) ? 32'd1 : 32'd0);
    check({tag, "_busy"},  32'(bus.BUSY), 32'd1);
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_valid"},   32'(bus.OUT_VALID), 32'd0);
    check({tag, "_data"},    bus.OUT_DATA, 32'd0);
    check({tag, "_index"},   32'(bus.OUT_INDEX), 32'd0);
    check({tag, "_last"},    32'(bus.OUT_LAST), 32'd0);
    check({tag, "_busy"},    32'(bus.BUSY), 32'd0);
    check({tag, "_overrun"}, 32'(bus.OVERRUN), 32'd0);
  endtask

  task automatic load(input logic [31:0] base);
    bus.STREAM_I = vec(base);
    bus.LOAD     = 1'b1;
    tick();
    bus.LOAD     = 1'b0;
  endtask

  initial begin
    logic [8:0] pat;
    int exp_k;
    int cyc;
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b1;
    bus.LOAD      = 1'b0;
    bus.ABORT     = 1'b0;
    bus.OUT_READY = 1'b0;
    bus.STREAM_I  = vec(A_BASE);
    #2 rst_n = 1'b0;
    #10;
    // Reset state
    expect_quiet("rst");
    check("rst_done", 32'(bus.DONE), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // 1: basic frame at full throughput
    bus.OUT_READY = 1'b1;
    load(A_BASE);
    for (int k = 0; k < NC; k++) begin
      expect_word("t1", A_BASE, k);
      check("t1_done_mid", 32'(bus.DONE), 32'd0);
      tick();
    end
    expect_quiet("t1_end");
    check("t1_done", 32'(bus.DONE), 32'd1);
    tick();
    check("t1_done_once", 32'(bus.DONE), 32'd0);

    // 2: ready pattern 1,0,0,1,0,1,0,0,1 -- no loss, no duplication, stable stalls
    bus.OUT_READY = 1'b0;
    load(A_BASE);
    pat   = 9'b100101001;  // bit c = ready in cycle c
    exp_k = 0;
    cyc   = 0;
    while (exp_k < NC && cyc < 20) begin
      expect_word("t2", A_BASE, exp_k);
      bus.OUT_READY = pat[cyc % 9];
      tick();
      if (bus.OUT_READY) exp_k++;
      cyc++;
    end
    check("t2_words", 32'(exp_k), 32'(NC));
    check("t2_done", 32'(bus.DONE), 32'd1);
    check("t2_valid_end", 32'(bus.OUT_VALID), 32'd0);
    bus.OUT_READY = 1'b1;
    tick();

    // 3: back-to-back frames, LOAD with the last transfer
    load(A_BASE);
    for (int k = 0; k < NC - 1; k++) begin
      expect_word("t3a", A_BASE, k);
      tick();
    end
    expect_word("t3a", A_BASE, NC - 1);
    load(B_BASE);
    check("t3_done_a", 32'(bus.DONE), 32'd1);
    expect_word("t3b", B_BASE, 0);
    tick();
    for (int k = 1; k < NC; k++) begin
      expect_word("t3b", B_BASE, k);
      check("t3_done_mid", 32'(bus.DONE), 32'd0);
      tick();
    end
    check("t3_done_b", 32'(bus.DONE), 32'd1);
    check("t3_busy_end", 32'(bus.BUSY), 32'd0);
    tick();

    // 4: LOAD at index 1 is dropped with an overrun pulse
    load(A_BASE);
    expect_word("t4", A_BASE, 0);
    tick();
    expect_word("t4", A_BASE, 1);
    check("t4_ovr_pre", 32'(bus.OVERRUN), 32'd0);
    load(B_BASE);
    check("t4_ovr", 32'(bus.OVERRUN), 32'd1);
    expect_word("t4", A_BASE, 2);
    tick();
    check("t4_ovr_once", 32'(bus.OVERRUN), 32'd0);
    expect_word("t4", A_BASE, 3);
    tick();
    check("t4_done", 32'(bus.DONE), 32'd1);
    tick();

    // 5: ABORT at index 2 with ready high, then ABORT+LOAD in IDLE, then restart
    load(A_BASE);
    for (int k = 0; k < 2; k++) begin
      expect_word("t5", A_BASE, k);
      tick();
    end
    expect_word("t5", A_BASE, 2);
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    expect_quiet("t5_abort");
    check("t5_no_done", 32'(bus.DONE), 32'd0);
    tick();
    check("t5_no_done2", 32'(bus.DONE), 32'd0);
    bus.ABORT = 1'b1;
    load(B_BASE);
    bus.ABORT = 1'b0;
    expect_quiet("t5_abort_load");
    load(B_BASE);
    for (int k = 0; k < NC; k++) begin
      expect_word("t5b", B_BASE, k);
      tick();
    end
    check("t5_done", 32'(bus.DONE), 32'd1);
    tick();

    // 6: reset at index 1 clears everything at once; idle afterwards
    load(A_BASE);
    expect_word("t6", A_BASE, 0);
    tick();
    expect_word("t6", A_BASE, 1);
    #2 rst_n = 1'b0;
    #1;
    expect_quiet("t6_rst");
    check("t6_rst_done", 32'(bus.DONE), 32'd0);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_quiet("t6_after");
      check("t6_after_done", 32'(bus.DONE), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
